pw_mem_arbiter: RTL and testbench

- Arbitrates one shared synchronous password memory between two requesters: port 0 (password verify path) and port 1 (password update/admin path).
- Serialises single-word read and write transactions with round-robin fairness.
- Drives the memory's address, write-enable and write data, honouring the fixed memory read latency.
- Returns read data and a completion pulse to the owning requester; sits between the access-control FSMs and the ROM/RAM password store.

---
 rtl/pw_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_pw_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pw_mem_arbiter
// Brief    : Round-robin arbiter that serialises two requesters onto one
//            synchronous password memory with a fixed read latency.
// Revision : 1.0 - initial release
// ============================================================================
module pw_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // WAIT spans RD_LAT-1 cycles; the counter runs down to zero on its last cycle.
  localparam logic [1:0] c_wait_init = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t     r_state;
  logic       r_owner;
  logic       r_last;
  logic       r_we;
  logic [1:0] r_cnt;

  logic w_win_valid;
  logic w_win;

  // On a tie the port that was not served last wins.
  assign w_win_valid = req0 | req1;
  assign w_win       = (req0 & req1) ? ~r_last : req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_we      <= 1'b0;
      r_cnt     <= 2'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wren  <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_owner   <= w_win;
            r_last    <= w_win;
            r_we      <= w_win ? we1 : we0;
            mem_addr  <= w_win ? addr1 : addr0;
            mem_wdata <= w_win ? wdata1 : wdata0;
            mem_wren  <= w_win ? we1 : we0;
            gnt0      <= ~w_win;
            gnt1      <= w_win;
            busy      <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          mem_wren <= 1'b0;
          if (r_we || (RD_LAT == 1)) begin
            if (!r_we) begin
              rdata <= mem_rdata;
            end
            ack0    <= ~r_owner;
            ack1    <= r_owner;
            r_state <= ST_ACK;
          end else begin
            r_cnt   <= c_wait_init;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            rdata   <= mem_rdata;
            ack0    <= ~r_owner;
            ack1    <= r_owner;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_ACK: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pw_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pw_mem_arbiter
// Brief    : Scoreboard bench for pw_mem_arbiter, RD_LAT=1 and RD_LAT=3 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pw_mem_arbiter;

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    int          gcyc;
    int          acyc;
  } txn_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int i);
    if (i == 2) return 16'hBEEF;
    if (i == 3) return 16'hC0DE;
    return 16'(16'h5A00 + i * 16'h0101);
  endfunction

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL inst%0d %s at cycle %0d: got %0h, expected %0h", inst, nm, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT  = (gi == 0) ? 1 : 3;
    localparam int DIDX = (LAT >= 2) ? LAT - 2 : 0;

    logic        rst = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, ack0, gnt1, ack1, mem_wren, busy;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] mem [16];
    logic [15:0] adl [4];
    bit          done = 1'b0;

    // Reference model state, advanced by the stimulus process.
    txn_t        gq[$];
    txn_t        aq[$];
    bit          pend [2];
    logic        pwe [2];
    logic [15:0] pad [2];
    logic [15:0] pwd [2];
    int          last_srv;
    int          free_edge;
    int          ngr;
    logic [15:0] last_rd;
    logic [15:0] mmem [16];

    pw_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .we0       (we0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .gnt0      (gnt0),
      .ack0      (ack0),
      .req1      (req1),
      .we1       (we1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .gnt1      (gnt1),
      .ack1      (ack1),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wren  (mem_wren),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    // Memory: data for an address shows up LAT-1 cycles after it is presented.
    always @(posedge clk) begin
      adl[0] <= mem_addr;
      for (int i = 1; i < 4; i++) adl[i] <= adl[i-1];
      if (cyc == 0) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else if (mem_wren) begin
        mem[mem_addr[3:0]] <= mem_wdata;
      end
    end
    assign mem_rdata = (LAT == 1) ? mem[mem_addr[3:0]] : mem[adl[DIDX][3:0]];

    task automatic drive();
      req0 = pend[0]; we0 = pwe[0]; addr0 = pad[0]; wdata0 = pwd[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = pad[1]; wdata1 = pwd[1];
    endtask

    task automatic post(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
      pend[p] = 1'b1; pwe[p] = w; pad[p] = a; pwd[p] = d;
    endtask

    task automatic model_reset();
      gq.delete(); aq.delete();
      last_srv = 1; free_edge = 0; last_rd = '0;
    endtask

    // Drive this cycle's requests and predict what the next edge does.
    task automatic tick();
      int k; int w; txn_t t;
      drive();
      k = cyc + 1;
      if (rst && k >= free_edge && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = (last_srv == 1) ? 0 : 1;
        else w = pend[0] ? 0 : 1;
        last_srv = w;
        t.port = w; t.we = pwe[w]; t.addr = pad[w]; t.wd = pwd[w];
        t.gcyc = k;
        t.acyc = k + (t.we ? 1 : LAT);
        if (t.we) begin
          t.rd = last_rd;
          mmem[t.addr[3:0]] = t.wd;
        end else begin
          t.rd = mmem[t.addr[3:0]];
          last_rd = t.rd;
        end
        free_edge = t.acyc + 2;
        gq.push_back(t);
        aq.push_back(t);
        pend[w] = 1'b0;
        ngr++;
      end
      @(negedge clk);
    endtask

    task automatic tick_until_grant();
      int g; int n;
      g = ngr; n = 0;
      while (ngr == g && n < 64) begin
        tick();
        n++;
      end
    endtask

    initial begin
      int g0; int n;
      for (int p = 0; p < 2; p++) begin
        pend[p] = 1'b0; pwe[p] = 1'b0; pad[p] = '0; pwd[p] = '0;
      end
      for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
      ngr = 0;
      model_reset();
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;

      post(0, 1'b0, 16'h0002, 16'h0000);
      tick_until_grant();
      repeat (6) tick();

      post(1, 1'b1, 16'h0001, 16'h1234);
      tick_until_grant();
      repeat (6) tick();

      // Both ports keep requesting: grants must alternate.
      g0 = ngr; n = 0;
      post(0, 1'b0, 16'h0003, 16'h0000);
      post(1, 1'b1, 16'h0005, 16'h00A5);
      while (ngr < g0 + 4 && n < 200) begin
        tick();
        if (!pend[0]) post(0, 1'b0, 16'h0003, 16'h0000);
        if (!pend[1]) post(1, 1'b1, 16'h0005, 16'h00A5);
        n++;
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      repeat (8) tick();

      // Port 1 pulses a request while port 0 is being served.
      post(0, 1'b0, 16'h0002, 16'h0000);
      tick_until_grant();
      post(1, 1'b1, 16'h0007, 16'hDEAD);
      tick();
      pend[1] = 1'b0;
      repeat (8) tick();

      // Reset one cycle after the grant of a read, with port 0 still requesting.
      post(0, 1'b0, 16'h0003, 16'h0000);
      tick_until_grant();
      tick();
      pend[0] = 1'b1;
      drive();
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk(gi, "rst_abort_ctl", 32'({gnt0, gnt1, ack0, ack1, busy, mem_wren}), 32'h0);
      chk(gi, "rst_abort_bus", {mem_addr, mem_wdata}, 32'h0);
      chk(gi, "rst_abort_rdata", 32'(rdata), 32'h0);
      @(negedge clk);
      #2 rst = 1'b1;
      tick_until_grant();
      repeat (6) tick();

      for (int i = 0; i < 600; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p]) begin
            if ($urandom_range(0, 99) < 35)
              post(p, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
          end else if ($urandom_range(0, 99) < 4) begin
            pend[p] = 1'b0;
          end
        end
        tick();
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      repeat (10) tick();
      done = 1'b1;
    end

    // Monitor: compares DUT outputs against the expected queues every cycle.
    initial begin
      txn_t        t;
      logic [15:0] m_addr, m_wd, m_rd;
      bit          bz;
      m_addr = '0; m_wd = '0; m_rd = '0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk(gi, "reset_ctl", 32'({gnt0, gnt1, ack0, ack1, busy, mem_wren}), 32'h0);
          chk(gi, "reset_bus", {mem_addr, mem_wdata}, 32'h0);
          chk(gi, "reset_rdata", 32'(rdata), 32'h0);
          m_addr = '0; m_wd = '0; m_rd = '0;
        end else begin
          if (gq.size() > 0 && gq[0].gcyc == cyc) begin
            t = gq.pop_front();
            chk(gi, "gnt", 32'({gnt1, gnt0}), (t.port == 1) ? 32'h2 : 32'h1);
            chk(gi, "issue_addr", 32'(mem_addr), 32'(t.addr));
            chk(gi, "issue_wren", 32'(mem_wren), 32'(t.we));
            chk(gi, "issue_wdata", 32'(mem_wdata), 32'(t.wd));
            m_addr = t.addr;
            m_wd = t.wd;
          end else begin
            chk(gi, "gnt_quiet", 32'({gnt1, gnt0}), 32'h0);
            chk(gi, "wren_quiet", 32'(mem_wren), 32'h0);
          end
          bz = (aq.size() > 0) && (aq[0].gcyc <= cyc);
          chk(gi, "busy", 32'(busy), 32'(bz));
          if (bz) begin
            chk(gi, "addr_hold", 32'(mem_addr), 32'(aq[0].addr));
          end else begin
            chk(gi, "idle_addr", 32'(mem_addr), 32'(m_addr));
            chk(gi, "idle_wdata", 32'(mem_wdata), 32'(m_wd));
            chk(gi, "idle_rdata", 32'(rdata), 32'(m_rd));
          end
          if (aq.size() > 0 && aq[0].acyc == cyc) begin
            t = aq.pop_front();
            chk(gi, "ack", 32'({ack1, ack0}), (t.port == 1) ? 32'h2 : 32'h1);
            chk(gi, "ack_rdata", 32'(rdata), 32'(t.rd));
            m_rd = t.rd;
          end else begin
            chk(gi, "ack_quiet", 32'({ack1, ack0}), 32'h0);
          end
        end
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_inst[0].done && g_inst[1].done) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d cycles without completion, limit 5000", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
